ram_param: RTL and testbench

Parametrised single-port synchronous RAM that replaces the fixed 256x64 ram used by the factorial system.
- Adds per-byte write enables, registered read with a valid strobe and range checking.
- Includes a hardware clear engine that zeroes the array after reset and on request, so the factorial core never reads stale operands.
- Sits behind the bus slave decode, next to the factorial core's operand/result storage.

---
 rtl/ram_param.sv | 154 +++++++++++++++
 tb/tb_ram_param.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_param.sv
// ram_param: single-port synchronous RAM with byte enables and a clear engine.
// Define RAM_PARITY_EN to store and check one even-parity bit per byte.
module ram_param #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cen,
  input  logic                wen,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [ADDR_W-1:0]   s_addr,
  input  logic [DATA_W-1:0]   s_din,
  output logic [DATA_W-1:0]   s_dout,
  output logic                dout_valid,
  output logic                addr_err,
  input  logic                clr_req,
  output logic                busy,
  input  logic                err_inj,
  output logic                par_err
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dout_n;
  logic              in_range;
  logic              last;
  logic              clr_we;
  logic              wr_en;
  logic              valid_n;
  logic              aerr_n;
  logic              perr_n;
  logic              rd_perr;

  assign in_range = 32'(s_addr) < 32'(DEPTH);
  assign last     = 32'(ptr) == 32'(DEPTH - 1);
  assign busy     = (state == CLEAR);
  assign rd_data  = in_range ? mem[s_addr] : '0;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) mem[s_addr][8*i +: 8] <= s_din[8*i +: 8];
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] rd_par;

  assign rd_par = in_range ? par[s_addr] : '0;

  always_comb begin
    rd_perr = 1'b0;
    for (int i = 0; i < NB; i++) begin
      rd_perr = rd_perr | ((^rd_data[8*i +: 8]) ^ rd_par[i]);
    end
  end

  // zero data has even parity 0, so a cleared word reads back clean
  always_ff @(posedge clk) begin
    if (clr_we) begin
      par[ptr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) par[s_addr][i] <= (^s_din[8*i +: 8]) ^ err_inj;
      end
    end
  end
`else
  logic unused_err_inj;

  assign unused_err_inj = err_inj;
  assign rd_perr        = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    clr_we  = 1'b0;
    wr_en   = 1'b0;
    dout_n  = s_dout;
    valid_n = 1'b0;
    aerr_n  = 1'b0;
    perr_n  = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we = 1'b1;
        dout_n = '0;
        if (last) begin
          state_n = IDLE;
          ptr_n   = '0;
        end else begin
          ptr_n = ptr + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_n = CLEAR;
          ptr_n   = '0;
          dout_n  = '0;
        end else if (!cen) begin
          dout_n = '0;
        end else if (wen) begin
          wr_en  = in_range;
          aerr_n = !in_range;
        end else begin
          valid_n = 1'b1;
          aerr_n  = !in_range;
          dout_n  = rd_data;
          perr_n  = in_range & rd_perr;
        end
      end
      default: begin
        state_n = CLEAR;
        ptr_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR;
      ptr        <= '0;
      s_dout     <= '0;
      dout_valid <= 1'b0;
      addr_err   <= 1'b0;
      par_err    <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      s_dout     <= dout_n;
      dout_valid <= valid_n;
      addr_err   <= aerr_n;
      par_err    <= perr_n;
    end
  end

endmodule

// File: tb/tb_ram_param.sv
// tb_ram_param: table vectors, hand sequences and random traffic for ram_param.
// A 200-word instance covers the out-of-range address path.
module tb_ram_param;

  localparam int D  = 256;
  localparam int D2 = 200;
`ifdef RAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        cen, wen, clr_req, err_inj;
  logic [7:0]  byte_en, s_addr;
  logic [63:0] s_din, s_dout;
  logic        dout_valid, addr_err, busy, par_err;

  logic        cen2, wen2;
  logic [7:0]  be2, addr2;
  logic [63:0] din2, dout2;
  logic        valid2, aerr2, busy2, perr2;

  int vectors = 0;
  int miss    = 0;

  ram_param #(.DATA_W(64), .ADDR_W(8), .DEPTH(D)) u_dut (
    .clk(clk), .reset_n(reset_n), .cen(cen), .wen(wen),
    .byte_en(byte_en), .s_addr(s_addr), .s_din(s_din),
    .s_dout(s_dout), .dout_valid(dout_valid), .addr_err(addr_err),
    .clr_req(clr_req), .busy(busy), .err_inj(err_inj),
    .par_err(par_err)
  );

  ram_param #(.DATA_W(64), .ADDR_W(8), .DEPTH(D2)) u_small (
    .clk(clk), .reset_n(reset_n), .cen(cen2), .wen(wen2),
    .byte_en(be2), .s_addr(addr2), .s_din(din2),
    .s_dout(dout2), .dout_valid(valid2), .addr_err(aerr2),
    .clr_req(1'b0), .busy(busy2), .err_inj(1'b0),
    .par_err(perr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model of the 256-word instance
  logic [63:0] m [D];
  logic [7:0]  p [D];
  int          clr_left;
  logic [63:0] e_dout;
  logic        e_valid, e_aerr, e_perr;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    clr_left = D;
    e_dout   = '0;
    e_valid  = 1'b0;
    e_aerr   = 1'b0;
    e_perr   = 1'b0;
  endtask

  task automatic model_step();
    logic bad;
    e_valid = 1'b0;
    e_aerr  = 1'b0;
    e_perr  = 1'b0;
    if (clr_left > 0) begin
      m[D - clr_left] = '0;
      p[D - clr_left] = '0;
      clr_left--;
      e_dout = '0;
    end else if (clr_req) begin
      clr_left = D;
      e_dout   = '0;
    end else if (!cen) begin
      e_dout = '0;
    end else if (wen) begin
      e_aerr = int'(s_addr) >= D;
      if (int'(s_addr) < D) begin
        for (int i = 0; i < 8; i++) begin
          if (byte_en[i]) begin
            m[s_addr][8*i +: 8] = s_din[8*i +: 8];
            p[s_addr][i] = (^s_din[8*i +: 8]) ^ (err_inj & PAR);
          end
        end
      end
    end else begin
      e_valid = 1'b1;
      e_aerr  = int'(s_addr) >= D;
      e_dout  = (int'(s_addr) < D) ? m[s_addr] : '0;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
        bad = bad | ((^m[s_addr][8*i +: 8]) != p[s_addr][i]);
      end
      e_perr = bad & PAR & (int'(s_addr) < D);
    end
  endtask

  task automatic apply();
    model_step();
    @(posedge clk);
    #1;
    chk("dout", s_dout, e_dout);
    chk("valid", 64'(dout_valid), 64'(e_valid));
    chk("addr_err", 64'(addr_err), 64'(e_aerr));
    chk("par_err", 64'(par_err), 64'(e_perr));
    chk("busy", 64'(busy), 64'(clr_left > 0));
  endtask

  task automatic idle();
    cen = 0; wen = 0; clr_req = 0; err_inj = 0;
    byte_en = '0; s_addr = '0; s_din = '0;
  endtask

  task automatic drive(input logic c, input logic w, input logic [7:0] be,
                       input logic [7:0] a, input logic [63:0] d);
    cen = c; wen = w; byte_en = be; s_addr = a; s_din = d;
  endtask

  task automatic count_busy(input int start_at, output int n, output int n2);
    n  = int'(busy);
    n2 = int'(busy2);
    for (int i = 0; i < 400; i++) begin
      clr_req = (i == start_at);
      apply();
      n  += int'(busy);
      n2 += int'(busy2);
      if (!busy && !busy2) break;
    end
    clr_req = 1'b0;
  endtask

  typedef struct {
    logic        c, w, err;
    logic [7:0]  be, addr;
    logic [63:0] din, x_dout;
    logic        x_valid, x_aerr, x_perr;
  } vec_t;

  vec_t tbl [13];
  int   n, n2;

  initial begin
    tbl[0]  = '{1, 1, 0, 8'hFF, 8'h01, 64'h1234_5678, 64'h0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 8'h00, 8'h01, 64'h0, 64'h1234_5678, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 8'h00, 8'h01, 64'h0, 64'h0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 8'hFF, 8'h02, 64'h1010_1010_1010_1010,
                64'h0, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 8'h0F, 8'h02, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 8'h00, 8'h02, 64'h0,
                64'h1010_1010_FFFF_FFFF, 1, 0, 0};
    tbl[6]  = '{1, 1, 0, 8'h00, 8'h02, 64'h0,
                64'h1010_1010_FFFF_FFFF, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 8'h00, 8'h02, 64'h0,
                64'h1010_1010_FFFF_FFFF, 1, 0, 0};
    tbl[8]  = '{1, 1, 1, 8'h01, 8'h03, 64'hAB,
                64'h1010_1010_FFFF_FFFF, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 8'h00, 8'h03, 64'h0, 64'hAB, 1, 0, PAR};
    tbl[10] = '{1, 1, 0, 8'h01, 8'h03, 64'hAB, 64'hAB, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 8'h00, 8'h03, 64'h0, 64'hAB, 1, 0, 0};
    tbl[12] = '{1, 0, 0, 8'h00, 8'h01, 64'h0, 64'h1234_5678, 1, 0, 0};

    for (int i = 0; i < D; i++) begin
      m[i] = '0;
      p[i] = '0;
    end
    idle();
    cen2 = 0; wen2 = 0; be2 = '0; addr2 = '0; din2 = '0;
    reset_n = 1'b0;
    #22;
    chk("rst dout", s_dout, 64'h0);
    chk("rst valid", 64'(dout_valid), 64'h0);
    chk("rst addr_err", 64'(addr_err), 64'h0);
    chk("rst par_err", 64'(par_err), 64'h0);
    chk("rst busy", 64'(busy), 64'h1);
    chk("rst busy2", 64'(busy2), 64'h1);
    model_reset();
    reset_n = 1'b1;

    count_busy(-1, n, n2);
    chk("busy cycles", 64'(n), 64'(D));
    chk("busy2 cycles", 64'(n2), 64'(D2));

    drive(1, 0, 8'h00, 8'h05, 64'h0);
    apply();
    chk("read 05", s_dout, 64'h0);
    chk("read 05 valid", 64'(dout_valid), 64'h1);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].c, tbl[i].w, tbl[i].be, tbl[i].addr, tbl[i].din);
      err_inj = tbl[i].err;
      apply();
      chk($sformatf("tbl%0d dout", i), s_dout, tbl[i].x_dout);
      chk($sformatf("tbl%0d valid", i), 64'(dout_valid),
          64'(tbl[i].x_valid));
      chk($sformatf("tbl%0d aerr", i), 64'(addr_err),
          64'(tbl[i].x_aerr));
      chk($sformatf("tbl%0d perr", i), 64'(par_err),
          64'(tbl[i].x_perr));
    end
    idle();

    // async reset in the middle of a read result
    drive(1, 0, 8'h00, 8'h01, 64'h0);
    apply();
    idle();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst dout", s_dout, 64'h0);
    chk("midrst valid", 64'(dout_valid), 64'h0);
    chk("midrst busy", 64'(busy), 64'h1);
    model_reset();
    @(posedge clk);
    #3 reset_n = 1'b1;
    count_busy(-1, n, n2);
    chk("busy after rst", 64'(n), 64'(D));

    drive(1, 1, 8'hFF, 8'h04, 64'h1111_1111);
    apply();
    drive(1, 0, 8'h00, 8'h04, 64'h0);
    clr_req = 1'b1;
    apply();
    chk("clr drop valid", 64'(dout_valid), 64'h0);
    chk("clr busy", 64'(busy), 64'h1);
    idle();
    count_busy(100, n, n2);
    chk("clr busy cycles", 64'(n), 64'(D));
    drive(1, 0, 8'h00, 8'h04, 64'h0);
    apply();
    chk("read 04 cleared", s_dout, 64'h0);
    chk("read 04 valid", 64'(dout_valid), 64'h1);

    for (int i = 0; i < 600; i++) begin
      clr_req = (clr_left == 0) && ($urandom_range(79) == 0);
      cen     = $urandom_range(3) != 0;
      wen     = $urandom_range(1) == 1;
      byte_en = $urandom_range(2) == 0 ? 8'hFF : 8'($urandom);
      s_addr  = 8'($urandom_range(15));
      s_din   = {$urandom, $urandom};
      err_inj = $urandom_range(5) == 0;
      apply();
    end
    idle();
    while (clr_left > 0) apply();

    cen2 = 1; wen2 = 1; be2 = 8'hFF; addr2 = 8'hF0; din2 = 64'h1111;
    apply();
    chk("oor wr aerr", 64'(aerr2), 64'h1);
    chk("oor wr valid", 64'(valid2), 64'h0);
    wen2 = 0;
    apply();
    chk("oor rd dout", dout2, 64'h0);
    chk("oor rd valid", 64'(valid2), 64'h1);
    chk("oor rd aerr", 64'(aerr2), 64'h1);
    chk("oor rd perr", 64'(perr2), 64'h0);
    wen2 = 1; addr2 = 8'hC7;
    apply();
    chk("c7 wr aerr", 64'(aerr2), 64'h0);
    wen2 = 0;
    apply();
    chk("c7 rd dout", dout2, 64'h1111);
    chk("c7 rd valid", 64'(valid2), 64'h1);
    chk("c7 rd aerr", 64'(aerr2), 64'h0);
    cen2 = 0;
    apply();
    chk("small idle aerr", 64'(aerr2), 64'h0);
    chk("small idle dout", dout2, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
